// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
//   Fractional-N baud timebase for the UART datapath. An integer countdown
//   plus a FRAC_W-bit phase accumulator give an average oversample period of
//   act_int + act_frac/2^FRAC_W hwclk cycles. Each individual period is
//   either act_int or act_int+1 cycles.
//
// Ports
//   hwclk         in   system clock, rising edge
//   rst           in   synchronous reset, active high, beats every other input
//   en            in   count enable; low freezes the timebase
//   resync        in   1-cycle pulse: restart the phase at the half-bit point
//   cfg_wr        in   1-cycle pulse: capture cfg_div_int / cfg_div_frac
//   cfg_div_int   in   oversample period, integer part (values 0/1 act as 2)
//   cfg_div_frac  in   oversample period, fractional part (2^-FRAC_W units)
//   cfg_pending   out  a divisor has been written but not yet applied
//   os_tick       out  1-cycle strobe at baud*OVERSAMPLE
//   baud_tick     out  1-cycle strobe once per bit, coincides with an os_tick
//   baud_clk      out  square wave, high while os_cnt >= OVERSAMPLE/2
// ----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int SOURCE_CLK = 12000000,
    parameter int TARGET_CLK = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 8,
    parameter int DEF_INT    = SOURCE_CLK / (TARGET_CLK * OVERSAMPLE),
    // 64-bit arithmetic: SOURCE_CLK * 2^FRAC_W overflows 32 bits.
    parameter int DEF_FRAC   = int'((longint'(SOURCE_CLK) * (longint'(1) << FRAC_W))
                                    / (longint'(TARGET_CLK) * longint'(OVERSAMPLE))
                                    % (longint'(1) << FRAC_W))
) (
    input  logic              hwclk,
    input  logic              rst,
    input  logic              en,
    input  logic              resync,
    input  logic              cfg_wr,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_pending,
    output logic              os_tick,
    output logic              baud_tick,
    output logic              baud_clk
);

    localparam int                OSW      = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  DEF_I    = DIV_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] DEF_F    = FRAC_W'(DEF_FRAC);
    localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(2);
    localparam logic [OSW-1:0]    OS_HALF  = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0]    OS_LAST  = OSW'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]  act_int, sh_int, cnt;
    logic [FRAC_W-1:0] act_frac, sh_frac, acc;
    logic [OSW-1:0]    os_cnt, os_cnt_nxt;

    logic              reload;
    logic              apply;
    logic [DIV_W-1:0]  sel_int_raw, sel_int;
    logic [FRAC_W-1:0] sel_frac;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W-1:0]  cnt_reload;

    // Reload point: end of an oversample period. resync takes priority and
    // suppresses the tick in its cycle.
    assign reload    = en & (cnt == '0) & ~resync;
    assign os_tick   = reload & ~rst;
    assign baud_tick = os_tick & (os_cnt == OS_LAST);

    // A divisor change only lands on a period boundary (reload or resync).
    // A write arriving on that same cycle bypasses the shadow register.
    assign apply = reload | resync;

    always_comb begin
        sel_int_raw = act_int;
        sel_frac    = act_frac;
        if (cfg_wr) begin
            sel_int_raw = cfg_div_int;
            sel_frac    = cfg_div_frac;
        end else if (cfg_pending) begin
            sel_int_raw = sh_int;
            sel_frac    = sh_frac;
        end
    end

    // Periods shorter than 2 cycles would merge adjacent strobes.
    assign sel_int    = (sel_int_raw < MIN_INT) ? MIN_INT : sel_int_raw;
    assign acc_sum    = {1'b0, acc} + {1'b0, sel_frac};
    assign cnt_reload = sel_int - DIV_W'(1) + DIV_W'(acc_sum[FRAC_W]);

    always_comb begin
        os_cnt_nxt = os_cnt;
        if (resync)
            os_cnt_nxt = OS_HALF;
        else if (reload)
            os_cnt_nxt = os_cnt + OSW'(1);
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            act_int     <= DEF_I;
            act_frac    <= DEF_F;
            sh_int      <= DEF_I;
            sh_frac     <= DEF_F;
            cfg_pending <= 1'b0;
            cnt         <= DEF_I - DIV_W'(1);
            acc         <= '0;
            os_cnt      <= '0;
            baud_clk    <= 1'b0;
        end else begin
            if (apply) begin
                act_int     <= sel_int;
                act_frac    <= sel_frac;
                cfg_pending <= 1'b0;
            end else if (cfg_wr) begin
                sh_int      <= cfg_div_int;
                sh_frac     <= cfg_div_frac;
                cfg_pending <= 1'b1;
            end

            if (resync) begin
                cnt <= sel_int - DIV_W'(1);
                acc <= '0;
            end else if (reload) begin
                cnt <= cnt_reload;
                acc <= acc_sum[FRAC_W-1:0];
            end else if (en) begin
                cnt <= cnt - DIV_W'(1);
            end

            os_cnt   <= os_cnt_nxt;
            // OVERSAMPLE is a power of two, so the MSB is the >= half decode.
            baud_clk <= os_cnt_nxt[OSW-1];
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;

    localparam int OS = 16;

    logic        hwclk = 1'b0;
    logic        rst, en, resync, cfg_wr;
    logic [15:0] cfg_div_int;
    logic [7:0]  cfg_div_frac;
    logic        cfg_pending, os_tick, baud_tick, baud_clk;

    always #5 hwclk = ~hwclk;

    baud_tick_gen dut (
        .hwclk        (hwclk),
        .rst          (rst),
        .en           (en),
        .resync       (resync),
        .cfg_wr       (cfg_wr),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_pending  (cfg_pending),
        .os_tick      (os_tick),
        .baud_tick    (baud_tick),
        .baud_clk     (baud_clk)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: cycles left until the next os tick, the fractional
    // residue, and the bit position, advanced with plain arithmetic.
    int m_left, m_acc, m_pos, m_aint, m_afrac, m_sint, m_sfrac;
    bit m_pend;

    function automatic void m_reset();
        m_aint = 78; m_afrac = 32; m_sint = 78; m_sfrac = 32;
        m_left = 78; m_acc = 0; m_pos = 0; m_pend = 0;
    endfunction

    function automatic void m_update(input bit tick);
        int ci, cf;
        if (rst) begin
            m_reset();
        end else if (resync || tick) begin
            if (cfg_wr) begin ci = int'(cfg_div_int); cf = int'(cfg_div_frac); end
            else if (m_pend) begin ci = m_sint; cf = m_sfrac; end
            else begin ci = m_aint; cf = m_afrac; end
            m_aint  = (ci < 2) ? 2 : ci;
            m_afrac = cf;
            m_pend  = 0;
            if (resync) begin
                m_left = m_aint; m_acc = 0; m_pos = OS / 2;
            end else begin
                m_left = m_aint + (m_acc + m_afrac) / 256;
                m_acc  = (m_acc + m_afrac) % 256;
                m_pos  = (m_pos + 1) % OS;
            end
        end else begin
            if (cfg_wr) begin
                m_sint = int'(cfg_div_int); m_sfrac = int'(cfg_div_frac); m_pend = 1;
            end
            if (en) m_left--;
        end
    endfunction

    logic s_os, s_baud, s_bclk, s_pend, prev_os;

    // One hwclk cycle: inputs already set after the falling edge; compare,
    // take the rising edge, advance the model, release pulse inputs.
    task automatic step();
        bit e_os;
        #1;
        e_os   = !rst && en && !resync && (m_left == 1);
        s_os   = os_tick; s_baud = baud_tick; s_bclk = baud_clk; s_pend = cfg_pending;
        check("os_tick", s_os, e_os);
        check("baud_tick", s_baud, e_os && (m_pos == OS - 1));
        check("baud_clk", s_bclk, m_pos >= OS / 2);
        check("cfg_pending", s_pend, m_pend);
        if (s_os) check("os_tick spacing", prev_os, 0);
        prev_os = s_os;
        @(posedge hwclk);
        m_update(e_os);
        @(negedge hwclk);
        cfg_wr = 0; resync = 0;
    endtask

    task automatic wait_os(input int bound, output int dt);
        dt = 0;
        do begin step(); dt++; end while (!s_os && dt < bound);
        check("os_tick arrival", s_os, 1);
    endtask

    task automatic wait_baud(input int bound, output int dt, output int hi);
        dt = 0; hi = 0;
        do begin step(); dt++; if (s_bclk) hi++; end while (!s_baud && dt < bound);
        check("baud_tick arrival", s_baud, 1);
    endtask

    typedef struct {
        int div_int;
        int div_frac;
        int exp_bit;   // cycles between successive baud_ticks
        int exp_high;  // baud_clk high cycles per bit, -1 = not checked
    } vec_t;

    vec_t vecs[$];

    initial begin
        int t, dt, hi, n, tb15, paused, frozen;
        bit bclk0;

        vecs.push_back('{4,   0,   64,   32});
        vecs.push_back('{1,   0,   32,   16});
        vecs.push_back('{0,   0,   32,   16});
        vecs.push_back('{100, 0,   1600, 800});
        vecs.push_back('{2,   128, 40,   -1});
        vecs.push_back('{10,  64,  164,  -1});
        vecs.push_back('{3,   240, 63,   -1});
        vecs.push_back('{78,  32,  1250, -1});

        rst = 1; en = 0; resync = 0; cfg_wr = 0; cfg_div_int = 0; cfg_div_frac = 0;
        prev_os = 0; tb15 = 0;
        m_reset();
        @(posedge hwclk); @(negedge hwclk);
        step();
        check("reset os_tick", s_os, 0);
        check("reset baud_tick", s_baud, 0);
        check("reset baud_clk", s_bclk, 0);
        check("reset cfg_pending", s_pend, 0);

        // 1: default timing against the closed form 78 + 78n + floor(32n/256)
        rst = 0; en = 1;
        wait_os(200, t);
        check("first os_tick cycle", t, 78);
        for (int k = 1; k <= 32; k++) begin
            wait_os(200, dt);
            t += dt;
            check("os_tick time", t, 78 + 78 * k + (32 * k) / 256);
            if (k == 15) tb15 = t;
            if (k == 31) check("default bit period", t - tb15, 1250);
        end

        // 2: mid-period divisor write, held in shadow until the next reload
        repeat (10) step();
        cfg_div_int = 4; cfg_div_frac = 0; cfg_wr = 1;
        step();
        step();
        check("pending after write", s_pend, 1);
        wait_os(200, dt);
        check("pending at applying tick", s_pend, 1);
        wait_os(200, dt);
        check("new os period", dt, 4);
        check("pending cleared", s_pend, 0);
        wait_baud(200, dt, hi);
        wait_baud(200, dt, hi);
        check("int4 bit period", dt, 64);
        check("int4 baud_clk high", hi, 32);

        // 3: resync at an arbitrary phase, then resync on a would-be tick
        repeat ($urandom_range(0, 40)) step();
        cfg_div_int = 78; cfg_div_frac = 32; cfg_wr = 1; resync = 1;
        step();
        check("no os_tick on resync", s_os, 0);
        t = 0; n = 0;
        do begin wait_os(200, dt); t += dt; n++; end while (!s_baud && n < 20);
        check("os_ticks to baud after resync", n, 8);
        check("cycles to baud after resync", t, 624);
        repeat (78) step();
        resync = 1;
        step();
        check("resync beats due tick", s_os, 0);
        t = 0; n = 0;
        do begin wait_os(200, dt); t += dt; n++; end while (!s_baud && n < 20);
        check("os_ticks to baud after resync 2", n, 8);
        check("acc cleared by resync", t, 624);

        // 4: freeze for 100 cycles mid-bit
        resync = 1;
        step();
        repeat (300) step();
        en = 0; paused = 0; frozen = 1; bclk0 = baud_clk;
        repeat (100) begin
            step();
            if (s_os || s_baud) paused++;
            if (s_bclk != bclk0) frozen = 0;
        end
        check("strobes while frozen", paused, 0);
        check("baud_clk frozen", frozen, 1);
        en = 1;
        wait_baud(2000, dt, hi);
        check("resume with remaining count", 400 + dt, 724);

        // 5: clamp of 1 and 0, and a write coincident with a reload
        cfg_div_int = 1; cfg_div_frac = 0; cfg_wr = 1;
        step();
        wait_os(200, dt);
        wait_os(200, dt);
        check("int1 clamps to 2", dt, 2);
        cfg_div_int = 0; cfg_wr = 1;
        step();
        wait_os(200, dt);
        wait_os(200, dt);
        check("int0 clamps to 2", dt, 2);
        step();
        cfg_div_int = 5; cfg_wr = 1;
        step();
        check("cfg_wr on tick cycle", s_os, 1);
        step();
        check("coincident write not pending", s_pend, 0);
        wait_os(200, dt);
        check("coincident write period", dt + 1, 5);

        // 6: reset mid-bit with a pending write
        resync = 1;
        step();
        repeat (200) step();
        cfg_div_int = 7; cfg_wr = 1;
        step();
        step();
        check("pending before reset", s_pend, 1);
        rst = 1;
        step();
        rst = 0;
        step();
        check("post-reset os_tick", s_os, 0);
        check("post-reset baud_clk", s_bclk, 0);
        check("post-reset pending", s_pend, 0);
        t = 1;
        wait_os(200, dt); t += dt;
        check("post-reset first os_tick", t, 78);
        wait_baud(2000, dt, hi); t += dt;
        check("post-reset first baud_tick", t, 1249);

        // Table: apply+resync each divisor, skip to a bit edge, time one bit
        foreach (vecs[i]) begin
            cfg_div_int = 16'(vecs[i].div_int); cfg_div_frac = 8'(vecs[i].div_frac);
            cfg_wr = 1; resync = 1;
            step();
            wait_baud(4000, dt, hi);
            wait_baud(4000, dt, hi);
            check("table bit period", dt, vecs[i].exp_bit);
            if (vecs[i].exp_high >= 0) check("table baud_clk high", hi, vecs[i].exp_high);
        end

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            en           = ($urandom_range(0, 9) != 0);
            resync       = ($urandom_range(0, 149) == 0);
            cfg_wr       = ($urandom_range(0, 39) == 0);
            cfg_div_int  = 16'($urandom_range(0, 9));
            cfg_div_frac = 8'($urandom_range(0, 255));
            step();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
